// File: rtl/tx_pcs_framer.sv
// Purpose : frame PCS adapter words into 8-bit {sync header, scrambled payload}, lock to MFI, insert marker at MFI 0.
// Latency : one register stage; the word presented before edge N+1 is visible on Tx_Word after edge N+1.
// Backpres: none -- one word per Ck in and out; Tx_Word_Vld marks framed words (SYNC only).
//
// Ports
//   Ck, Rs          clock; synchronous active-low reset
//   Tx_PCS_MFI      multiframe index 0-255 from the PCS adapter
//   Tx_PCS_SH_Res   overhead bit carried in the sync header of non-marker words
//   Tx_PCS_Dat      6-bit payload
//   Scr_En          1 = apply keystream, 0 = keystream forced to zero (LFSR still runs)
//   Tx_Word         [7:6] sync header, [5:0] payload
//   Tx_Word_Vld     Tx_Word holds a framed word
//   Lock            tracker is in SYNC
//   Mfi_Err         one-cycle pulse on an MFI mismatch while in SYNC
//   Mfi_Err_Cnt     saturating count of Mfi_Err pulses

module tx_pcs_framer #(
    parameter int unsigned LOSS_TH    = 4,       // 1..15 consecutive misses before dropping lock
    parameter logic [5:0]  AM_PAYLOAD = 6'h2A,
    parameter logic [6:0]  SCR_SEED   = 7'h7F,
    parameter int unsigned ERR_CNT_W  = 16
) (
    input  logic                 Ck,
    input  logic                 Rs,
    input  logic [7:0]           Tx_PCS_MFI,
    input  logic                 Tx_PCS_SH_Res,
    input  logic [5:0]           Tx_PCS_Dat,
    input  logic                 Scr_En,
    output logic [7:0]           Tx_Word,
    output logic                 Tx_Word_Vld,
    output logic                 Lock,
    output logic                 Mfi_Err,
    output logic [ERR_CNT_W-1:0] Mfi_Err_Cnt
);

    typedef enum logic {
        HUNT = 1'b0,
        SYNC = 1'b1
    } state_t;

    localparam logic [3:0]           LOSS_LIM = 4'(LOSS_TH);
    localparam logic [ERR_CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [7:0]           IDLE     = 8'h00;

    // Registered state
    state_t               state;
    logic [7:0]           exp_mfi;
    logic [3:0]           miss_cnt;
    logic [6:0]           lfsr;

    // Next-state / next-output values
    state_t               state_nxt;
    logic [7:0]           exp_mfi_nxt;
    logic [3:0]           miss_nxt;
    logic [6:0]           lfsr_nxt;
    logic [7:0]           word_nxt;
    logic                 vld_nxt;
    logic                 err_nxt;
    logic [ERR_CNT_W-1:0] cnt_nxt;

    // Datapath helpers
    logic [5:0]           key_raw;
    logic [5:0]           key;
    logic [6:0]           lfsr_adv;
    logic                 is_am;
    logic [7:0]           built_word;
    logic [3:0]           miss_inc;

    // Six LFSR steps (x^7+x^6+1). Returns {keystream[5:0], new state}.
    // The first generated bit lands in keystream bit 5, the last in bit 0,
    // so the keystream lines up MSB-first with the payload.
    function automatic logic [12:0] lfsr_run6(input logic [6:0] s_in);
        logic [6:0] s;
        logic [5:0] k;
        logic       o;
        s = s_in;
        k = '0;
        for (int i = 5; i >= 0; i--) begin
            o    = s[6] ^ s[5];
            k[i] = o;
            s    = {s[5:0], o};
        end
        return {k, s};
    endfunction

    always_comb begin
        {key_raw, lfsr_adv} = lfsr_run6(lfsr);
        key        = Scr_En ? key_raw : 6'h00;
        is_am      = (Tx_PCS_MFI == 8'd0);
        // Marker words carry a fixed 2'b11 header, so SH_Res is not transmitted for them.
        built_word = is_am ? {2'b11, AM_PAYLOAD}
                           : {Tx_PCS_SH_Res, ~Tx_PCS_SH_Res, Tx_PCS_Dat ^ key};
        miss_inc   = miss_cnt + 4'd1;
    end

    // Next-state and output decode
    always_comb begin
        state_nxt   = state;
        exp_mfi_nxt = exp_mfi;
        miss_nxt    = miss_cnt;
        // The scrambler free-runs in both states; only the marker position reseeds it,
        // so the receiver can recover the keystream from the marker alone.
        lfsr_nxt    = is_am ? SCR_SEED : lfsr_adv;
        word_nxt    = IDLE;
        vld_nxt     = 1'b0;
        err_nxt     = 1'b0;
        cnt_nxt     = Mfi_Err_Cnt;

        case (state)
            HUNT: begin
                if (is_am) begin
                    state_nxt   = SYNC;
                    exp_mfi_nxt = 8'd1;
                    miss_nxt    = 4'd0;
                    word_nxt    = built_word;
                    vld_nxt     = 1'b1;
                end
            end

            SYNC: begin
                // Always track the received index, so a single slip costs one miss
                // and the following in-order word already matches again.
                exp_mfi_nxt = Tx_PCS_MFI + 8'd1;
                if (Tx_PCS_MFI == exp_mfi) begin
                    miss_nxt = 4'd0;
                    word_nxt = built_word;
                    vld_nxt  = 1'b1;
                end else begin
                    err_nxt = 1'b1;
                    if (!(&Mfi_Err_Cnt)) begin
                        cnt_nxt = Mfi_Err_Cnt + CNT_ONE;
                    end
                    if (miss_inc == LOSS_LIM) begin
                        // Lock lost: this word already goes out as idle.
                        state_nxt = HUNT;
                        miss_nxt  = 4'd0;
                    end else begin
                        miss_nxt = miss_inc;
                        word_nxt = built_word;
                        vld_nxt  = 1'b1;
                    end
                end
            end

            default: begin
                state_nxt = HUNT;
            end
        endcase
    end

    always_ff @(posedge Ck) begin
        if (!Rs) begin
            state       <= HUNT;
            exp_mfi     <= 8'd0;
            miss_cnt    <= 4'd0;
            lfsr        <= SCR_SEED;
            Tx_Word     <= IDLE;
            Tx_Word_Vld <= 1'b0;
            Mfi_Err     <= 1'b0;
            Mfi_Err_Cnt <= '0;
        end else begin
            state       <= state_nxt;
            exp_mfi     <= exp_mfi_nxt;
            miss_cnt    <= miss_nxt;
            lfsr        <= lfsr_nxt;
            Tx_Word     <= word_nxt;
            Tx_Word_Vld <= vld_nxt;
            Mfi_Err     <= err_nxt;
            Mfi_Err_Cnt <= cnt_nxt;
        end
    end

    assign Lock = (state == SYNC);

endmodule
